// File: rtl/bit_serial_adder_seq_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding
// and the default operand width.
package bit_serial_adder_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_adder_seq_fa_pg_cell.sv
// Combinational propagate/generate full-adder cell. The carry-out is formed
// by the caller from prop/gen so the carry flop can live in the sequencer.
module fa_pg_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic prop,
    output logic gen,
    output logic sout
);

    assign prop = a ^ b;
    assign gen  = a & b;
    assign sout = prop ^ cin;

endmodule

// File: rtl/bit_serial_adder_seq.sv
// Bit-serial adder sequencer: LSB-first add over WIDTH cycles, result returned
// over valid/ready. Define SUB_MODE_EN to add the 'sub' port (A - B mode).
module bit_serial_adder_seq
    import bit_serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SUB_MODE_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             all_prop
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic               prop_q, prop_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic sub_sel;
    logic bit_p, bit_g, bit_s;

`ifdef SUB_MODE_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    fa_pg_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .prop (bit_p),
        .gen  (bit_g),
        .sout (bit_s)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        prop_d    = prop_q;
        count_d   = count_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtraction is A + ~B + 1, so the forced carry replaces cin.
                    a_d     = op_a;
                    b_d     = op_b ^ {WIDTH{sub_sel}};
                    carry_d = sub_sel | cin;
                    prop_d  = 1'b1;
                    count_d = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                carry_d = bit_g | (bit_p & carry_q);
                prop_d  = prop_q & bit_p;
                count_d = count_q + 1'b1;
                if (count_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result pins read zero except while a result is being offered.
    assign sum      = out_valid ? res_q : '0;
    assign cout     = out_valid & carry_q;
    assign all_prop = out_valid & prop_q;

    // NOTE: datapath regs are reset alongside the FSM so no stale result survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            prop_q  <= 1'b1;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            prop_q  <= prop_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_bit_serial_adder_seq.sv
// Directed self-checking bench for bit_serial_adder_seq (WIDTH=8); exercises
// the subtract path as well when SUB_MODE_EN is defined.
module tb_bit_serial_adder_seq;

    localparam int W = 8;
    localparam int MAX_WAIT = 100;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
`ifdef SUB_MODE_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         all_prop;

    int pass_cnt;
    int total_cnt;

    bit_serial_adder_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef SUB_MODE_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .all_prop  (all_prop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one operand pair for a single edge, then counts edges until
    // out_valid. Returns at a negedge with out_valid high (unless timed out).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, output int lat);
        @(negedge clk);
        op_a     = a;
        op_b     = b;
        cin      = c;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < MAX_WAIT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] exp_sum,
                                input logic exp_cout, input logic exp_ap, input int lat);
        total_cnt++;
        if (lat !== W) $display("FAIL %s latency: got %0d expected %0d", name, lat, W);
        else pass_cnt++;
        total_cnt++;
        if (sum !== exp_sum) $display("FAIL %s sum: got %h expected %h", name, sum, exp_sum);
        else pass_cnt++;
        total_cnt++;
        if (cout !== exp_cout) $display("FAIL %s cout: got %b expected %b", name, cout, exp_cout);
        else pass_cnt++;
        total_cnt++;
        if (all_prop !== exp_ap) $display("FAIL %s all_prop: got %b expected %b", name, all_prop, exp_ap);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
`ifdef SUB_MODE_EN
        sub       = 1'b0;
`endif
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({in_ready, out_valid, sum, cout, all_prop} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b ap=%b expected rdy=1 vld=0 sum=00 cout=0 ap=0",
                     in_ready, out_valid, sum, cout, all_prop);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat;
        out_ready = 1'b1;
        run_op(8'h5A, 8'h3C, 1'b0, lat);
        check_result("add_5a_3c", 8'h96, 1'b0, 1'b0, lat);
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL add_handshake: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
        else pass_cnt++;

        run_op(8'hFF, 8'h01, 1'b0, lat);
        check_result("add_ff_01", 8'h00, 1'b1, 1'b0, lat);
        @(negedge clk);

        run_op(8'hF0, 8'h0F, 1'b1, lat);
        check_result("add_f0_0f_cin", 8'h00, 1'b1, 1'b1, lat);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        out_ready = 1'b0;
        run_op(8'h12, 8'h34, 1'b0, lat);
        check_result("bp_12_34", 8'h46, 1'b0, 1'b0, lat);
        // Foreign operands offered while the result is pending must be ignored.
        op_a     = 8'hFF;
        op_b     = 8'hFF;
        cin      = 1'b1;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sum !== 8'h46 || out_valid !== 1'b1 || in_ready !== 1'b0 || cout !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
        else pass_cnt++;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        out_ready = 1'b1;
        @(negedge clk);
        op_a     = 8'hAA;
        op_b     = 8'h55;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({in_ready, out_valid, sum, cout, all_prop} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL mid_run_reset: got rdy=%b vld=%b sum=%h cout=%b ap=%b expected rdy=1 vld=0 sum=00 cout=0 ap=0",
                     in_ready, out_valid, sum, cout, all_prop);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h01, 8'h01, 1'b0, lat);
        check_result("after_reset_01_01", 8'h02, 1'b0, 1'b0, lat);
        @(negedge clk);
    endtask

`ifdef SUB_MODE_EN
    task automatic test_sub();
        int lat;
        out_ready = 1'b1;
        sub = 1'b1;
        run_op(8'h10, 8'h01, 1'b0, lat);
        check_result("sub_10_01", 8'h0F, 1'b1, 1'b0, lat);
        @(negedge clk);
        run_op(8'h01, 8'h02, 1'b1, lat);
        check_result("sub_01_02", 8'hFF, 1'b0, 1'b0, lat);
        @(negedge clk);
        sub = 1'b0;
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_add();
        test_backpressure();
        test_reset_mid_run();
`ifdef SUB_MODE_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
